// File: rtl/conv_ld_pkg.sv
// conv_ld_pkg
//   Shared types and constants for the conv input DDR read steering block.
//   - info_entry_t : one outstanding DDR burst {target buffer, start word
//                    address in that buffer, burst length in words}
//   - ld_state_t   : request FSM states (IDLE, ISSUE, DRAIN)
//   - BYTES_PER_WORD : DDR byte stride of one DDR word
//   The CONV_LD_* widths are the defaults of the top-level parameters; the
//   info entry is built from them, so the top parameters that feed the entry
//   (LEN_W, BUF_NUM, BUF_ADR_W, DATA_W) must be kept equal to these values.
package conv_ld_pkg;

  localparam int CONV_LD_DATA_W    = 512;
  localparam int CONV_LD_LEN_W     = 16;
  localparam int CONV_LD_BUF_NUM   = 3;
  localparam int CONV_LD_BUF_IDX_W = $clog2(CONV_LD_BUF_NUM);
  localparam int CONV_LD_BUF_ADR_W = 12;

  localparam int BYTES_PER_WORD = CONV_LD_DATA_W / 8;

  typedef struct packed {
    logic [CONV_LD_BUF_IDX_W-1:0] buf_idx;
    logic [CONV_LD_BUF_ADR_W-1:0] buf_adr;
    logic [CONV_LD_LEN_W-1:0]     len;
  } info_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } ld_state_t;

endpackage

// File: rtl/conv_ld_info_fifo.sv
// conv_ld_info_fifo
//   Synchronous FIFO of outstanding-burst descriptors (info_entry_t).
//   Ports:
//     clk, reset      : clock, synchronous active-high reset (flushes FIFO)
//     push, push_data : write request / entry; ignored while full
//     pop             : remove head entry; ignored while empty
//     head            : current head entry (valid when !empty)
//     full, empty     : status
//     count           : number of stored entries (0..DEPTH)
//   DEPTH must be a power of two and at least 2. A push and a pop in the
//   same cycle are both honoured; full is a plain occupancy check, so a
//   full FIFO rejects a push even if it pops in that cycle.
module conv_ld_info_fifo
  import conv_ld_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  info_entry_t              push_data,
  input  logic                     pop,
  output info_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  info_entry_t      mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/conv_input_ddr_rd_steer.sv
// conv_input_ddr_rd_steer
//   Splits tile-row load requests into DDR read bursts of at most MAX_BURST
//   words, records each issued burst in an info FIFO, and steers returning
//   DDR words into one of BUF_NUM input row buffers at auto-incrementing,
//   wrapping word addresses.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     req_*                      : load request (valid/ready handshake)
//     ddr_cmd_*                  : DDR read command (valid/ready handshake)
//     ddr_rd_valid, ddr_rd_data  : returning DDR read words, in order
//     buf_wr_en/adr/data         : one-hot row buffer write port (registered)
//     busy                       : a non-empty request is in progress
//     done                       : one-cycle pulse when a request completes
//     err_orphan                 : sticky, data arrived with nothing pending
//   Optional feature macro CONV_LD_PERF_CNT_EN adds saturating counters
//   perf_words (words written) and perf_stall (command stall cycles).
module conv_input_ddr_rd_steer
  import conv_ld_pkg::*;
#(
  parameter int DATA_W     = CONV_LD_DATA_W,
  parameter int DDR_ADR_W  = 32,
  parameter int LEN_W      = CONV_LD_LEN_W,
  parameter int BUF_NUM    = CONV_LD_BUF_NUM,
  parameter int BUF_ADR_W  = CONV_LD_BUF_ADR_W,
  parameter int MAX_BURST  = 64,
  parameter int INFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DDR_ADR_W-1:0]       req_ddr_adr,
  input  logic [LEN_W-1:0]           req_len,
  input  logic [$clog2(BUF_NUM)-1:0] req_buf_idx,
  input  logic [BUF_ADR_W-1:0]       req_buf_adr,
  output logic                       ddr_cmd_valid,
  input  logic                       ddr_cmd_ready,
  output logic [DDR_ADR_W-1:0]       ddr_cmd_adr,
  output logic [LEN_W-1:0]           ddr_cmd_len,
  input  logic                       ddr_rd_valid,
  input  logic [DATA_W-1:0]          ddr_rd_data,
  output logic [BUF_NUM-1:0]         buf_wr_en,
  output logic [BUF_ADR_W-1:0]       buf_wr_adr,
  output logic [DATA_W-1:0]          buf_wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err_orphan
`ifdef CONV_LD_PERF_CNT_EN
  ,
  output logic [31:0]                perf_words,
  output logic [31:0]                perf_stall
`endif
);

  localparam int IDX_W = $clog2(BUF_NUM);
  localparam int CNT_W = $clog2(INFO_DEPTH) + 1;

  ld_state_t             state;
  logic [LEN_W-1:0]      remaining;
  logic [LEN_W-1:0]      chunk;
  logic [DDR_ADR_W-1:0]  cur_ddr_adr;
  logic [IDX_W-1:0]      cur_buf_idx;
  logic [BUF_ADR_W-1:0]  cur_buf_adr;
  logic                  req_fire;
  logic                  cmd_fire;

  info_entry_t           push_entry;
  info_entry_t           head_entry;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_next;
  logic                  room_next;

  logic [LEN_W-1:0]      head_off;
  logic                  rd_take;
  logic                  head_last;

  assign chunk       = (remaining > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : remaining;
  assign req_fire    = req_valid && req_ready;
  assign cmd_fire    = ddr_cmd_valid && ddr_cmd_ready;
  assign ddr_cmd_adr = cur_ddr_adr;
  assign ddr_cmd_len = chunk;

  assign fifo_push  = cmd_fire;
  assign push_entry = '{buf_idx: cur_buf_idx, buf_adr: cur_buf_adr, len: chunk};

  // Occupancy after this edge; lets the registered command valid drop the
  // cycle the FIFO fills and rise again the cycle after a slot frees up.
  assign count_next = fifo_count + CNT_W'(fifo_push && !fifo_full) - CNT_W'(fifo_pop);
  assign room_next  = (count_next != CNT_W'(INFO_DEPTH));

  assign rd_take   = ddr_rd_valid && !fifo_empty;
  assign head_last = (head_off == head_entry.len - 1'b1);
  assign fifo_pop  = rd_take && head_last;

  conv_ld_info_fifo #(
    .DEPTH (INFO_DEPTH)
  ) u_info_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Request FSM: accepts a request, issues bursts while FIFO space allows,
  // then waits for every burst to be written back before signalling done.
  // DRAIN sees the FIFO empty in the same cycle the final word is on the
  // buffer write port, so done follows the last write by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      ddr_cmd_valid <= 1'b0;
      remaining     <= '0;
      cur_ddr_adr   <= '0;
      cur_buf_idx   <= '0;
      cur_buf_adr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            if (req_len == '0) begin
              done <= 1'b1;
            end else begin
              remaining     <= req_len;
              cur_ddr_adr   <= req_ddr_adr;
              cur_buf_idx   <= req_buf_idx;
              cur_buf_adr   <= req_buf_adr;
              busy          <= 1'b1;
              req_ready     <= 1'b0;
              ddr_cmd_valid <= room_next;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ddr_cmd_valid <= room_next;
          if (cmd_fire) begin
            remaining   <= remaining - chunk;
            cur_ddr_adr <= cur_ddr_adr + DDR_ADR_W'(chunk) * DDR_ADR_W'(BYTES_PER_WORD);
            cur_buf_adr <= cur_buf_adr + BUF_ADR_W'(chunk);
            if (remaining == chunk) begin
              ddr_cmd_valid <= 1'b0;
              state         <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write path, independent of the FSM: each returning word goes to the
  // head burst's buffer at its start address plus the word offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_wr_en   <= '0;
      buf_wr_adr  <= '0;
      buf_wr_data <= '0;
      head_off    <= '0;
      err_orphan  <= 1'b0;
    end else begin
      buf_wr_en <= '0;
      if (rd_take) begin
        buf_wr_en   <= BUF_NUM'(1) << head_entry.buf_idx;
        buf_wr_adr  <= head_entry.buf_adr + BUF_ADR_W'(head_off);
        buf_wr_data <= ddr_rd_data;
        head_off    <= head_last ? '0 : head_off + 1'b1;
      end else if (ddr_rd_valid) begin
        err_orphan <= 1'b1;
      end
    end
  end

`ifdef CONV_LD_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_words <= '0;
      perf_stall <= '0;
    end else begin
      if ((buf_wr_en != '0) && (perf_words != '1))
        perf_words <= perf_words + 1'b1;
      if (((ddr_cmd_valid && !ddr_cmd_ready) || ((state == ISSUE) && fifo_full))
          && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_input_ddr_rd_steer.sv
// tb_conv_input_ddr_rd_steer
//   Directed self-checking bench for conv_input_ddr_rd_steer (INFO_DEPTH=2
//   so the full-FIFO stall is reachable). A negedge monitor logs commands,
//   buffer writes and done pulses; the linear stimulus compares the logs
//   against hand-computed commands, addresses and data.
module tb_conv_input_ddr_rd_steer;

  localparam int DATA_W    = 512;
  localparam int DDR_ADR_W = 32;
  localparam int LEN_W     = 16;
  localparam int BUF_NUM   = 3;
  localparam int BUF_ADR_W = 12;

  logic                  clk;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [DDR_ADR_W-1:0]  req_ddr_adr;
  logic [LEN_W-1:0]      req_len;
  logic [1:0]            req_buf_idx;
  logic [BUF_ADR_W-1:0]  req_buf_adr;
  logic                  ddr_cmd_valid;
  logic                  ddr_cmd_ready;
  logic [DDR_ADR_W-1:0]  ddr_cmd_adr;
  logic [LEN_W-1:0]      ddr_cmd_len;
  logic                  ddr_rd_valid;
  logic [DATA_W-1:0]     ddr_rd_data;
  logic [BUF_NUM-1:0]    buf_wr_en;
  logic [BUF_ADR_W-1:0]  buf_wr_adr;
  logic [DATA_W-1:0]     buf_wr_data;
  logic                  busy;
  logic                  done;
  logic                  err_orphan;
`ifdef CONV_LD_PERF_CNT_EN
  logic [31:0]           perf_words;
  logic [31:0]           perf_stall;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int cmd_words = 0;
  int words_fed = 0;
  int done_cnt = 0;
  int done_cycle = -1;
  int last_wr_cycle = -1;
  int cmd_valid_cnt = 0;

  logic [31:0] cmd_adr_q [$];
  int          cmd_len_q [$];
  logic [2:0]  wr_en_q   [$];
  int          wr_adr_q  [$];
  logic [31:0] wr_data_q [$];

  conv_input_ddr_rd_steer #(
    .INFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_ddr_adr   (req_ddr_adr),
    .req_len       (req_len),
    .req_buf_idx   (req_buf_idx),
    .req_buf_adr   (req_buf_adr),
    .ddr_cmd_valid (ddr_cmd_valid),
    .ddr_cmd_ready (ddr_cmd_ready),
    .ddr_cmd_adr   (ddr_cmd_adr),
    .ddr_cmd_len   (ddr_cmd_len),
    .ddr_rd_valid  (ddr_rd_valid),
    .ddr_rd_data   (ddr_rd_data),
    .buf_wr_en     (buf_wr_en),
    .buf_wr_adr    (buf_wr_adr),
    .buf_wr_data   (buf_wr_data),
    .busy          (busy),
    .done          (done),
    .err_orphan    (err_orphan)
`ifdef CONV_LD_PERF_CNT_EN
    ,
    .perf_words    (perf_words),
    .perf_stall    (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: samples mid-cycle, logging command handshakes, writes and done.
  always @(negedge clk) begin
    if (ddr_cmd_valid) cmd_valid_cnt++;
    if (ddr_cmd_valid && ddr_cmd_ready) begin
      cmd_adr_q.push_back(ddr_cmd_adr);
      cmd_len_q.push_back(int'(ddr_cmd_len));
      cmd_words += int'(ddr_cmd_len);
    end
    if (buf_wr_en != '0) begin
      wr_en_q.push_back(buf_wr_en);
      wr_adr_q.push_back(int'(buf_wr_adr));
      wr_data_q.push_back(buf_wr_data[31:0]);
      last_wr_cycle = cycle;
    end
    if (done) begin
      done_cnt++;
      done_cycle = cycle;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one load request and returns the cycle in which it was accepted.
  task automatic applyStimulus(input logic [31:0] adr, input int len, input int idx,
                               input int badr, output int accept_cycle);
    int waited = 0;
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_ddr_adr = adr;
    req_len     = LEN_W'(len);
    req_buf_idx = 2'(idx);
    req_buf_adr = BUF_ADR_W'(badr);
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) checkOutput("req_accept_timeout", 64'd0, 64'd1);
    accept_cycle = cycle;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // DDR model: returns words in order, never ahead of issued commands.
  task automatic feed_words(input int n, input bit gap, input int base);
    int waited;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ddr_rd_valid = 1'b0;
      waited = 0;
      while (words_fed >= cmd_words && waited < 300) begin
        @(posedge clk); #1;
        waited++;
      end
      if (waited >= 300) begin
        checkOutput("feed_timeout", 64'd0, 64'd1);
        return;
      end
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = {480'd0, 32'(base + i)};
      words_fed++;
      if (gap) begin
        @(posedge clk); #1;
        ddr_rd_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    ddr_rd_valid = 1'b0;
  endtask

  task automatic wait_cmds(input int n_total, input int budget);
    int waited = 0;
    while (cmd_adr_q.size() < n_total && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= budget) checkOutput("cmd_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int n_total, input int budget);
    int waited = 0;
    while (done_cnt < n_total && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= budget) checkOutput("done_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_writes(input string tag, input int start, input int n,
                              input logic [2:0] en, input int badr, input int dbase);
    int avail;
    avail = wr_en_q.size() - start;
    checkOutput({tag, "_wr_count"}, 64'(avail), 64'(n));
    for (int i = 0; i < n && i < avail; i++) begin
      checkOutput($sformatf("%s_wr_en[%0d]", tag, i), 64'(wr_en_q[start+i]), 64'(en));
      checkOutput($sformatf("%s_wr_adr[%0d]", tag, i), 64'(wr_adr_q[start+i]),
                  64'((badr + i) % 4096));
      checkOutput($sformatf("%s_wr_data[%0d]", tag, i), 64'(wr_data_q[start+i]),
                  64'(32'(dbase + i)));
    end
  endtask

  task automatic check_cmd(input string tag, input int k, input logic [31:0] adr,
                           input int len);
    if (k < cmd_adr_q.size()) begin
      checkOutput({tag, "_adr"}, 64'(cmd_adr_q[k]), 64'(adr));
      checkOutput({tag, "_len"}, 64'(cmd_len_q[k]), 64'(len));
    end else begin
      checkOutput({tag, "_missing"}, 64'(cmd_adr_q.size()), 64'(k + 1));
    end
  endtask

  initial begin
    int acc;
    int c0;
    int w0;
    int d0;
    int v0;

    reset = 1'b1;
    req_valid = 1'b0;
    req_ddr_adr = '0;
    req_len = '0;
    req_buf_idx = '0;
    req_buf_adr = '0;
    ddr_cmd_ready = 1'b1;
    ddr_rd_valid = 1'b0;
    ddr_rd_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_cmd_valid", 64'(ddr_cmd_valid), 64'd0);
    checkOutput("rst_wr_en", 64'(buf_wr_en), 64'd0);
    checkOutput("rst_err_orphan", 64'(err_orphan), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Step 1: single short burst into buffer 1
    $display("[TB] step 1: len=10 single burst");
    c0 = cmd_adr_q.size(); w0 = wr_en_q.size(); d0 = done_cnt;
    applyStimulus(32'h1000, 10, 1, 0, acc);
    @(negedge clk);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_req_ready", 64'(req_ready), 64'd0);
    wait_cmds(c0 + 1, 50);
    feed_words(10, 1'b0, 32'h100);
    wait_done(d0 + 1, 50);
    repeat (3) @(negedge clk);
    checkOutput("t1_cmd_count", 64'(cmd_adr_q.size() - c0), 64'd1);
    check_cmd("t1_cmd0", c0, 32'h1000, 10);
    check_writes("t1", w0, 10, 3'b010, 0, 32'h100);
    checkOutput("t1_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("t1_done_after_last_wr", 64'(done_cycle), 64'(last_wr_cycle + 1));
    checkOutput("t1_busy_after", 64'(busy), 64'd0);
    checkOutput("t1_req_ready_after", 64'(req_ready), 64'd1);

    // Step 2: request longer than MAX_BURST splits into 64/64/22
    $display("[TB] step 2: len=150 split");
    c0 = cmd_adr_q.size(); w0 = wr_en_q.size(); d0 = done_cnt;
    applyStimulus(32'h0, 150, 0, 100, acc);
    feed_words(150, 1'b0, 32'h1000);
    wait_done(d0 + 1, 100);
    repeat (3) @(negedge clk);
    checkOutput("t2_cmd_count", 64'(cmd_adr_q.size() - c0), 64'd3);
    check_cmd("t2_cmd0", c0, 32'h0000, 64);
    check_cmd("t2_cmd1", c0 + 1, 32'h1000, 64);
    check_cmd("t2_cmd2", c0 + 2, 32'h2000, 22);
    check_writes("t2", w0, 150, 3'b001, 100, 32'h1000);
    checkOutput("t2_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("t2_done_after_last_wr", 64'(done_cycle), 64'(last_wr_cycle + 1));

    // Step 3: buffer address wraps at 4096
    $display("[TB] step 3: buffer address wrap");
    c0 = cmd_adr_q.size(); w0 = wr_en_q.size(); d0 = done_cnt;
    applyStimulus(32'h0002_0000, 4, 2, 4094, acc);
    feed_words(4, 1'b0, 32'h2000);
    wait_done(d0 + 1, 50);
    repeat (3) @(negedge clk);
    check_cmd("t3_cmd0", c0, 32'h0002_0000, 4);
    check_writes("t3", w0, 4, 3'b100, 4094, 32'h2000);
    checkOutput("t3_wr_adr2_wrapped", 64'(wr_adr_q[w0+2]), 64'd0);

    // Step 4: command back-pressure holds adr/len stable
    $display("[TB] step 4: ddr_cmd_ready low");
    ddr_cmd_ready = 1'b0;
    c0 = cmd_adr_q.size(); w0 = wr_en_q.size(); d0 = done_cnt;
    applyStimulus(32'h3000, 8, 0, 10, acc);
    begin
      int waited = 0;
      while (!ddr_cmd_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) checkOutput("t4_valid_timeout", 64'd0, 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4_hold_valid[%0d]", i), 64'(ddr_cmd_valid), 64'd1);
      checkOutput($sformatf("t4_hold_adr[%0d]", i), 64'(ddr_cmd_adr), 64'h3000);
      checkOutput($sformatf("t4_hold_len[%0d]", i), 64'(ddr_cmd_len), 64'd8);
      @(negedge clk);
    end
    checkOutput("t4_no_handshake_yet", 64'(cmd_adr_q.size() - c0), 64'd0);
    @(posedge clk); #1;
    ddr_cmd_ready = 1'b1;
    feed_words(8, 1'b0, 32'h400);
    wait_done(d0 + 1, 50);
    repeat (3) @(negedge clk);
    checkOutput("t4_cmd_count", 64'(cmd_adr_q.size() - c0), 64'd1);
    check_cmd("t4_cmd0", c0, 32'h3000, 8);
    check_writes("t4", w0, 8, 3'b001, 10, 32'h400);

    // Step 5: 4 bursts through a 2-entry info FIFO, data every other cycle
    $display("[TB] step 5: FIFO full stall");
    c0 = cmd_adr_q.size(); w0 = wr_en_q.size(); d0 = done_cnt;
    applyStimulus(32'h0001_0000, 256, 1, 32'h800, acc);
    wait_cmds(c0 + 2, 50);
    repeat (3) @(negedge clk);
    checkOutput("t5_stall_cmd_valid", 64'(ddr_cmd_valid), 64'd0);
    checkOutput("t5_stall_cmd_count", 64'(cmd_adr_q.size() - c0), 64'd2);
    checkOutput("t5_stall_busy", 64'(busy), 64'd1);
    feed_words(256, 1'b1, 32'h5000);
    wait_done(d0 + 1, 200);
    repeat (3) @(negedge clk);
    checkOutput("t5_cmd_count", 64'(cmd_adr_q.size() - c0), 64'd4);
    check_cmd("t5_cmd0", c0, 32'h0001_0000, 64);
    check_cmd("t5_cmd1", c0 + 1, 32'h0001_1000, 64);
    check_cmd("t5_cmd2", c0 + 2, 32'h0001_2000, 64);
    check_cmd("t5_cmd3", c0 + 3, 32'h0001_3000, 64);
    check_writes("t5", w0, 256, 3'b010, 32'h800, 32'h5000);
    checkOutput("t5_done_count", 64'(done_cnt - d0), 64'd1);

    // Step 6: orphan data in IDLE, then a zero-length request
    $display("[TB] step 6: orphan data and len=0");
    w0 = wr_en_q.size(); d0 = done_cnt;
    @(posedge clk); #1;
    ddr_rd_valid = 1'b1;
    ddr_rd_data  = {480'd0, 32'hDEAD};
    @(posedge clk); #1;
    ddr_rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t6_orphan_no_write", 64'(wr_en_q.size() - w0), 64'd0);
    checkOutput("t6_err_orphan_set", 64'(err_orphan), 64'd1);
    v0 = cmd_valid_cnt;
    applyStimulus(32'h5000, 0, 0, 0, acc);
    wait_done(d0 + 1, 10);
    repeat (3) @(negedge clk);
    checkOutput("t6_len0_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("t6_len0_done_cycle", 64'(done_cycle), 64'(acc + 1));
    checkOutput("t6_len0_no_cmd_valid", 64'(cmd_valid_cnt - v0), 64'd0);
    checkOutput("t6_len0_busy", 64'(busy), 64'd0);
    checkOutput("t6_err_orphan_sticky", 64'(err_orphan), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_err_orphan_cleared", 64'(err_orphan), 64'd0);
    checkOutput("t6_req_ready_reset", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_input_ddr_rd_steer.md
Name: conv_input_ddr_rd_steer

Overview:
Parametrised successor to the conv input DDR load path. It accepts tile-row load requests and splits each into DDR read bursts no longer than MAX_BURST. It tracks outstanding bursts in an internal info FIFO and steers returning DDR words into one of BUF_NUM input row buffers, with auto-incrementing, wrapping buffer addresses. It sits between the conv load-input address generator and the DDR read port / input row buffers, and replaces the external load_input_info_fifo plus glue logic.

Parameters:
DATA_W, 512, DDR word width in bits
DDR_ADR_W, 32, DDR byte address width
LEN_W, 16, request length width (words)
BUF_NUM, 3, number of input row buffers
BUF_ADR_W, 12, row buffer word address width (4096 words)
MAX_BURST, 64, max words per DDR command
INFO_DEPTH, 16, outstanding-burst FIFO depth (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  load request valid
req_ready  out  1  request accepted when valid&ready
req_ddr_adr  in  DDR_ADR_W  DDR byte base address
req_len  in  LEN_W  words to load
req_buf_idx  in  $clog2(BUF_NUM)  target row buffer
req_buf_adr  in  BUF_ADR_W  start word address in buffer
ddr_cmd_valid  out  1  DDR read command valid
ddr_cmd_ready  in  1  DDR accepts command
ddr_cmd_adr  out  DDR_ADR_W  burst byte address
ddr_cmd_len  out  LEN_W  burst length (words)
ddr_rd_valid  in  1  DDR read data valid
ddr_rd_data  in  DATA_W  DDR read data
buf_wr_en  out  BUF_NUM  one-hot buffer write enable
buf_wr_adr  out  BUF_ADR_W  buffer write address
buf_wr_data  out  DATA_W  buffer write data
busy  out  1  request in progress
done  out  1  one-cycle pulse: last word of request written
err_orphan  out  1  sticky: data arrived with no outstanding burst

Behaviour:
- Reset: all outputs 0 except req_ready=1; FSM to IDLE; info FIFO flushed; counters cleared. Reset mid-operation aborts silently (no done pulse); data in flight is discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: req_ready=1. On accept with req_len>0: latch fields, go to ISSUE, busy=1. On accept with req_len==0: pulse done next cycle, stay in IDLE, issue no command.
- ISSUE: chunk = min(remaining, MAX_BURST).
  - ddr_cmd_valid is asserted only when the info FIFO is not full.
  - adr/len are held stable while valid && !ready.
  - On handshake: push {buf_idx, buf_adr, chunk}; remaining -= chunk; ddr_adr += chunk*(DATA_W/8); buf_adr = (buf_adr+chunk) mod 2^BUF_ADR_W.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: wait until the info FIFO is empty and the last write has been issued; then pulse done, clear busy, go to IDLE.
- Write path (independent of FSM):
  - On ddr_rd_valid with the FIFO non-empty, register data; the write appears exactly 1 cycle later on buf_wr_* with buf_wr_en = 1<<head.buf_idx.
  - Head address increments per word and wraps at 2^BUF_ADR_W. Head count decrements; the entry pops on its final word.
  - A push and a pop in the same cycle are both honoured. A FIFO that is full but popping still rejects the push (simple full check).
- ddr_rd_valid with the FIFO empty: data dropped, no write, err_orphan set until reset.
- Address arithmetic is unsigned and wraps modulo 2^DDR_ADR_W without error.

Optional Feature:
CONV_LD_PERF_CNT_EN:
- When defined, adds outputs perf_words (32b, words written) and perf_stall (32b, cycles with ddr_cmd_valid&&!ddr_cmd_ready, or ISSUE blocked by a full FIFO). Both saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_ld_pkg: info entry struct {buf_idx, buf_adr, len}, the BYTES_PER_WORD constant, and the FSM state enum.
- One sub-module, conv_ld_info_fifo: synchronous FIFO, INFO_DEPTH entries, with full/empty/count outputs.

Test Plan:
1. req_len=10, adr=0x1000, buf_idx=1, buf_adr=0, ddr_cmd_ready=1, data every cycle -> one command (0x1000, 10); buf_wr_en=3'b010 on adr 0..9; done after the 10th write.
2. req_len=150, MAX_BURST=64 -> commands (0x0,64), (0x1000,64), (0x2000,22); 150 contiguous writes; done once.
3. buf_adr=4094, len=4 -> writes at 4094, 4095, 0, 1.
4. ddr_cmd_ready low 5 cycles, then high -> cmd adr/len stable throughout; exactly one handshake.
5. ddr_rd_valid toggling every other cycle (current DDR model), INFO_DEPTH=2 with 4 bursts -> ISSUE stalls on full; all words are written in order to the correct buffers.
6. ddr_rd_valid pulse in IDLE -> no buf_wr_en; err_orphan=1 until reset. req_len=0 -> done 1 cycle after accept, no ddr_cmd_valid.
